mem_responder: RTL and testbench

Memory-side responder for the core/memory request fabric. It consumes the arbitrated `request_t` stream from the interconnect's `mem_req` output and services reads and writes against an internal word array. It returns `request_t` response beats on `mem_rsp`, tagged with the originating `core_id`, so the interconnect can route each beat back to the requesting core. Incoming requests are buffered in a small FIFO, because the fabric has no backpressure path.

---
 rtl/mem_fabric_pkg.sv | 19 +
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fabric_pkg.sv
// Shared types for the core/memory request fabric.
// request_t carries both requests (core -> memory) and response beats (memory -> core).
package mem_fabric_pkg;

    localparam int unsigned CoreIdW = 4;
    localparam int unsigned LenW    = 8;
    localparam int unsigned AddrW   = 32;
    localparam int unsigned DataW   = 32;

    typedef struct packed {
        logic               vld;
        logic [CoreIdW-1:0] core_id;
        logic [LenW-1:0]    access_length;
        logic               rw;             // 1 = write
        logic [AddrW-1:0]   addr;
        logic [DataW-1:0]   data;
    } request_t;

endpackage

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core/memory request fabric.
// Buffers incoming requests in a small FIFO (the fabric has no backpressure), then services
// them one at a time against an internal word array, returning response beats tagged with the
// requesting core_id.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-low reset
//   mem_req      - request from the interconnect (vld, core_id, access_length, rw, addr, data)
//   mem_rsp      - response beat (read data or write ack), all zeros when no beat is issued
//   busy         - FSM not idle or FIFO non-empty
//   overflow_err - sticky, set when a request is dropped on a full FIFO
//   rd_beat_cnt  - saturating read-beat counter (only with MEM_RESPONDER_STATS_EN)
//   wr_cnt       - saturating write counter (only with MEM_RESPONDER_STATS_EN)
//
// Optional feature: define MEM_RESPONDER_STATS_EN to add the two statistics counters.
module mem_responder
    import mem_fabric_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 1024,  // power of two
    parameter int unsigned FIFO_DEPTH = 4      // power of two, >= 2
) (
    input  logic        clk,
    input  logic        reset,
    input  request_t    mem_req,
    output request_t    mem_rsp,
    output logic        busy,
    output logic        overflow_err
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_beat_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FullCnt = (FW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    // Only the array-index bits of the address are kept in the queue.
    typedef struct packed {
        logic [CoreIdW-1:0] core_id;
        logic [LenW-1:0]    len;
        logic               rw;
        logic [AW-1:0]      addr;
        logic [DataW-1:0]   data;
    } entry_t;

    logic [1:0]         state_q;
    entry_t             fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FW:0]        count_q;
    logic [DataW-1:0]   ram [MEM_DEPTH];

    logic [CoreIdW-1:0] work_core_q;
    logic [LenW-1:0]    work_len_q;
    logic [DataW-1:0]   work_data_q;
    logic [AW-1:0]      beat_addr_q;
    logic [LenW-1:0]    beats_left_q;

    logic               fifo_empty, fifo_full, pop, push;
    entry_t             head, req_entry;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^mem_req.addr[AddrW-1:AW];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign pop        = (state_q == StIdle) && !fifo_empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push       = mem_req.vld && (!fifo_full || pop);
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign head       = fifo_mem[rd_ptr_q];

    always_comb begin
        req_entry         = '0;
        req_entry.core_id = mem_req.core_id;
        req_entry.len     = mem_req.access_length;
        req_entry.rw      = mem_req.rw;
        req_entry.addr    = mem_req.addr[AW-1:0];
        req_entry.data    = mem_req.data;
    end

    // Queue storage and array contents are never reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr_q] <= req_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == StWrite) begin
            ram[beat_addr_q] <= work_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_rsp      <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (mem_req.vld && fifo_full && !pop) overflow_err <= 1'b1;

            mem_rsp <= '0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        work_core_q  <= head.core_id;
                        work_len_q   <= head.len;
                        work_data_q  <= head.data;
                        beat_addr_q  <= head.addr;
                        beats_left_q <= (head.len == '0) ? LenW'(1) : head.len;
                        state_q      <= head.rw ? StWrite : StRead;
                    end
                end
                StRead: begin
                    mem_rsp.vld           <= 1'b1;
                    mem_rsp.core_id       <= work_core_q;
                    mem_rsp.access_length <= work_len_q;
                    mem_rsp.rw            <= 1'b0;
                    mem_rsp.addr          <= AddrW'(beat_addr_q);
                    // Synchronous array read: data lands in the beat register on this edge.
                    mem_rsp.data          <= ram[beat_addr_q];
                    beat_addr_q           <= beat_addr_q + 1'b1;  // wraps modulo MEM_DEPTH
                    beats_left_q          <= beats_left_q - 1'b1;
                    if (beats_left_q == LenW'(1)) state_q <= StIdle;
                end
                StWrite: begin
                    mem_rsp.vld           <= 1'b1;
                    mem_rsp.core_id       <= work_core_q;
                    mem_rsp.access_length <= work_len_q;
                    mem_rsp.rw            <= 1'b1;
                    mem_rsp.addr          <= AddrW'(beat_addr_q);
                    mem_rsp.data          <= work_data_q;
                    state_q               <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_beat_cnt <= '0;
            wr_cnt      <= '0;
        end else begin
            if (state_q == StRead && rd_beat_cnt != '1) rd_beat_cnt <= rd_beat_cnt + 1'b1;
            if (state_q == StWrite && wr_cnt != '1)     wr_cnt      <= wr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver predicts every response beat (content and
// arrival edge) from a request-level service model and queues it; a monitor checks beats.
module tb_mem_responder;
    import mem_fabric_pkg::*;

    localparam int unsigned MEM_DEPTH  = 1024;
    localparam int unsigned FIFO_DEPTH = 4;

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    request_t mem_req = '0;
    request_t mem_rsp;
    logic     busy, overflow_err;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_beat_cnt, wr_cnt;
`endif

    mem_responder #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_rsp      (mem_rsp),
        .busy         (busy),
`ifdef MEM_RESPONDER_STATS_EN
        .rd_beat_cnt  (rd_beat_cnt),
        .wr_cnt       (wr_cnt),
`endif
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0, fails = 0;

    // Scoreboard: expected beat, edge it is registered on, whether its data is known.
    request_t exp_q[$];
    int       exp_t[$];
    bit       exp_k[$];

    // Reference model state.
    logic [31:0] mdl_mem [MEM_DEPTH];
    bit          mdl_known [MEM_DEPTH];
    int          pend_pop[$];  // pop edges of accepted, not-yet-popped requests
    int          srv_free = 0; // earliest edge the next pop can happen
    bit          exp_ovf = 0;
    int          mdl_rd = 0, mdl_wr = 0;
    int          beats_seen = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        request_t e, got;
        int       et;
        bit       k;
        if (reset) begin
            if (mem_rsp.vld) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h, expected none", mem_rsp);
                end else begin
                    e   = exp_q.pop_front();
                    et  = exp_t.pop_front();
                    k   = exp_k.pop_front();
                    got = mem_rsp;
                    if (!k) begin
                        got.data = '0;
                        e.data   = '0;
                    end
                    check("beat", got, e);
                    check("beat_edge", edge_n, et);
                    beats_seen++;
                end
            end else begin
                check("idle_zero", mem_rsp, '0);
            end
        end
    end

    function automatic void model_reset();
        exp_q.delete();
        exp_t.delete();
        exp_k.delete();
        pend_pop.delete();
        srv_free = 0;
        exp_ovf  = 0;
        mdl_rd   = 0;
        mdl_wr   = 0;
    endfunction

    // Drives one request for one edge and predicts its outcome.
    task automatic issue(bit rw, int core, int len, logic [31:0] addr, logic [31:0] data);
        int          t, p, n;
        int unsigned a;
        request_t    r, e;
        t = edge_n + 1;
        while (pend_pop.size() > 0 && pend_pop[0] < t) void'(pend_pop.pop_front());
        r               = '0;
        r.vld           = 1'b1;
        r.core_id       = CoreIdW'(core);
        r.access_length = LenW'(len);
        r.rw            = rw;
        r.addr          = addr;
        r.data          = data;
        mem_req = r;
        if (pend_pop.size() >= FIFO_DEPTH && pend_pop[0] != t) begin
            exp_ovf = 1;
        end else begin
            p = (t + 1 > srv_free) ? t + 1 : srv_free;
            n = rw ? 1 : (len == 0 ? 1 : len);
            pend_pop.push_back(p);
            srv_free = p + n + 1;
            for (int k = 0; k < n; k++) begin
                e               = '0;
                e.vld           = 1'b1;
                e.core_id       = r.core_id;
                e.access_length = r.access_length;
                e.rw            = rw;
                a = ((addr % MEM_DEPTH) + k) % MEM_DEPTH;
                e.addr = a;
                if (rw) begin
                    e.data       = data;
                    mdl_mem[a]   = data;
                    mdl_known[a] = 1;
                    mdl_wr++;
                end else begin
                    e.data = mdl_mem[a];
                    mdl_rd++;
                end
                exp_q.push_back(e);
                exp_t.push_back(p + 1 + k);
                exp_k.push_back(mdl_known[a]);
            end
        end
        @(negedge clk); #1;
        mem_req = '0;
    endtask

    task automatic idle(int n);
        mem_req = '0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic drain(string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 3000) begin
            @(negedge clk); #1;
            i++;
        end
        check(name, {exp_q.size() != 0, busy}, 2'b00);
    endtask

    task automatic do_reset(string name);
        reset   = 1'b0;
        mem_req = '0;
        repeat (2) begin
            @(negedge clk); #1;
        end
        model_reset();
        check({name, "_rsp"}, mem_rsp, '0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_ovf"}, overflow_err, 1'b0);
`ifdef MEM_RESPONDER_STATS_EN
        check({name, "_cnt"}, {rd_beat_cnt, wr_cnt}, 64'd0);
`endif
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        int base;
        logic [31:0] ra;

        do_reset("reset");

        // Write then read back-to-back
        issue(1, 2, 1, 32'd5, 32'hA5);
        issue(0, 2, 1, 32'd5, 32'h0);
        drain("wr_rd_drain");

        // Burst wrapping past the top of the array
        issue(1, 1, 1, 32'd1022, 32'd1);
        issue(1, 1, 1, 32'd1023, 32'd2);
        issue(1, 1, 1, 32'd0, 32'd3);
        issue(1, 1, 1, 32'd1, 32'd4);
        drain("preload_drain");
        base = beats_seen;
        issue(0, 1, 4, 32'd1022, 32'h0);
        drain("wrap_drain");
        check("wrap_beats", beats_seen - base, 4);

        // Length zero means one beat
        base = beats_seen;
        issue(0, 7, 0, 32'd5, 32'h0);
        drain("len0_drain");
        check("len0_beats", beats_seen - base, 1);

        // Overflow: long read then five back-to-back requests
        base = beats_seen;
        issue(0, 3, 8, 32'd0, 32'h0);
        for (int i = 0; i < 5; i++) issue(0, 4 + i, 1, 32'(1022 + i), 32'h0);
        drain("ovf_drain");
        check("ovf_flag", overflow_err, 1'b1);
        check("ovf_beats", beats_seen - base, 12);

        // Reset during beat 3 of a length-8 read
        base = beats_seen;
        issue(0, 3, 8, 32'd100, 32'h0);
        for (int i = 0; i < 40 && beats_seen < base + 3; i++) begin
            @(negedge clk); #1;
        end
        check("midburst_started", beats_seen - base, 3);
        reset = 1'b0;
        @(negedge clk); #1;
        model_reset();
        check("midburst_rsp", mem_rsp, '0);
        check("midburst_busy", busy, 1'b0);
        reset = 1'b1;
        idle(1);
        check("midburst_ovf", overflow_err, 1'b0);
        // Array contents survive reset
        issue(0, 2, 1, 32'd5, 32'h0);
        drain("retain_drain");

        // Statistics
        do_reset("reset2");
        issue(1, 0, 1, 32'd10, 32'h11);
        issue(1, 0, 1, 32'd11, 32'h22);
        issue(1, 0, 1, 32'd12, 32'h33);
        idle(6);
        issue(0, 0, 5, 32'd10, 32'h0);
        drain("stats_drain");
`ifdef MEM_RESPONDER_STATS_EN
        check("stats_wr", wr_cnt, 32'd3);
        check("stats_rd", rd_beat_cnt, 32'd5);
`endif

        // Randomized traffic; upper address bits are noise on reads
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                issue(1, $urandom_range(0, 15), $urandom_range(0, 6),
                      32'($urandom_range(0, 63)), $urandom);
            end else begin
                ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
                issue(0, $urandom_range(0, 15), $urandom_range(0, 6), ra, 32'h0);
            end
            idle($urandom_range(0, 3));
        end
        drain("rand_drain");
        check("rand_ovf", overflow_err, exp_ovf);
`ifdef MEM_RESPONDER_STATS_EN
        check("rand_wr_cnt", wr_cnt, mdl_wr);
        check("rand_rd_cnt", rd_beat_cnt, mdl_rd);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
